// File: rtl/logic_unit_pipe_pkg.sv
// logic_pkg: opcode encoding shared by the logic unit pipeline
package logic_pkg;
   localparam int OP_W = 3;
   typedef enum logic [OP_W-1:0] {
      OP_AND, OP_OR, OP_XOR, OP_NOR, OP_ANDN, OP_PASS_A, OP_PASS_B, OP_RSVD
   } op_t;
endpackage

// File: rtl/logic_unit_pipe_slice.sv
// pipe_slice: one elastic valid/ready register slice
// ports: clk, rst (sync, active-high), flush (drop held beat),
//        up_valid/up_ready/up_data (producer side), dn_valid/dn_ready/dn_data (consumer side)
module pipe_slice #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          up_valid,
   output logic          up_ready,
   input  logic [DW-1:0] up_data,
   output logic          dn_valid,
   input  logic          dn_ready,
   output logic [DW-1:0] dn_data
);
   logic          r_valid;
   logic [DW-1:0] r_data;
   assign up_ready = !r_valid || dn_ready;
   assign dn_valid = r_valid;
   assign dn_data  = r_data;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else begin
         if (flush) r_valid <= 1'b0;
         else if (up_ready) r_valid <= up_valid;
         if (up_ready && up_valid) r_data <= up_data;
      end
   end
endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: selectable bitwise op on two operands, carried through STAGES elastic slices
// ports: clk, rst (sync, active-high), flush (drop all in-flight beats),
//        in_valid/in_ready with op, a, b (input beat),
//        out_valid/out_ready with result, zero, all_ones, illegal (output beat)
module logic_unit_pipe
   import logic_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             all_ones,
   output logic             illegal
);
   localparam int DW = WIDTH + 3;
   op_t              w_op;
   logic [WIDTH-1:0] w_res;
   logic [DW-1:0]    w_pay;
   assign w_op = op_t'(op);
   always_comb begin
      w_res = w_op == OP_AND    ? a & b    :
              w_op == OP_OR     ? a | b    :
              w_op == OP_XOR    ? a ^ b    :
              w_op == OP_NOR    ? ~(a | b) :
              w_op == OP_ANDN   ? a & ~b   :
              w_op == OP_PASS_A ? a        :
              w_op == OP_PASS_B ? b        : '0;
   end
   // payload layout {illegal, all_ones, zero, result}; reserved op yields 0 so zero=1, all_ones=0
   assign w_pay = {w_op == OP_RSVD, &w_res, ~|w_res, w_res};
   // per-slice scalar handshake wires keep the ready chain free of self-referencing vectors
   for (genvar i = 0; i < STAGES; i++) begin : g_s
      logic          w_vi, w_ri, w_vo, w_ro;
      logic [DW-1:0] w_di, w_do;
      pipe_slice #(.DW(DW)) u_slice (
         .clk      (clk),
         .rst      (rst),
         .flush    (flush),
         .up_valid (w_vi),
         .up_ready (w_ri),
         .up_data  (w_di),
         .dn_valid (w_vo),
         .dn_ready (w_ro),
         .dn_data  (w_do)
      );
      if (i == 0) begin : g_f
         assign w_vi = in_valid;
         assign w_di = w_pay;
      end else begin : g_m
         assign w_vi = g_s[i-1].w_vo;
         assign w_di = g_s[i-1].w_do;
      end
      if (i == STAGES - 1) begin : g_e
         assign w_ro = out_ready;
      end else begin : g_n
         assign w_ro = g_s[i+1].w_ri;
      end
   end
   assign in_ready  = g_s[0].w_ri;
   assign out_valid = g_s[STAGES-1].w_vo;
   assign {illegal, all_ones, zero, result} = g_s[STAGES-1].w_do;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: randomized scoreboard bench for logic_unit_pipe
module tb_logic_unit_pipe;
   typedef struct packed {
      logic        il;
      logic        ao;
      logic        z;
      logic [31:0] r;
   } exp_t;

   logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [2:0]  op;
   logic [31:0] a, b, result;
   logic        zero, all_ones, illegal;

   logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
   logic [2:0]  s_op;
   logic [7:0]  s_a, s_b, s_result;
   logic        s_zero, s_all_ones, s_illegal;

   int   total, bad, rx_cnt;
   exp_t q[$];

   logic_unit_pipe #(.WIDTH(32), .STAGES(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .zero(zero), .all_ones(all_ones), .illegal(illegal)
   );

   logic_unit_pipe #(.WIDTH(8), .STAGES(1)) dut8 (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .op(s_op), .a(s_a),
      .b(s_b), .flush(1'b0), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .result(s_result), .zero(s_zero), .all_ones(s_all_ones), .illegal(s_illegal)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      exp_t e;
      logic [31:0] r;
      case (o)
         3'd0: r = x & y;
         3'd1: r = x | y;
         3'd2: r = x ^ y;
         3'd3: r = ~(x | y);
         3'd4: r = x & ~y;
         3'd5: r = x;
         3'd6: r = y;
         default: r = 32'd0;
      endcase
      e.r  = r;
      e.z  = (r == 32'd0);
      e.ao = (r == 32'hFFFF_FFFF);
      e.il = (o == 3'd7);
      return e;
   endfunction

   task automatic step(output bit acc, output bit stalled);
      @(negedge clk);
      acc     = in_valid && in_ready;
      stalled = in_valid && !in_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic monitor();
      exp_t        e;
      logic        stall;
      logic [31:0] held;
      stall = 1'b0;
      held  = '0;
      forever begin
         @(negedge clk);
         if (stall) begin
            total++;
            if (out_valid !== 1'b1 || result !== held) begin
               bad++;
               $display("FAIL stall_hold: out_valid=%b result=%h, required 1 %h", out_valid, result, held);
            end
         end
         stall = out_valid && !out_ready && !rst && !flush;
         held  = result;
         if (rst) q.delete();
         else begin
            if (out_valid && out_ready) begin
               rx_cnt++;
               total++;
               if (q.size() == 0) begin
                  bad++;
                  $display("FAIL scoreboard_extra: unexpected beat result=%h", result);
               end else begin
                  e = q.pop_front();
                  if ({illegal, all_ones, zero, result} !== e) begin
                     bad++;
                     $display("FAIL scoreboard: got il=%b ao=%b z=%b r=%h, required il=%b ao=%b z=%b r=%h",
                              illegal, all_ones, zero, result, e.il, e.ao, e.z, e.r);
                  end
               end
            end
            if (flush) q.delete();
            else if (in_valid && in_ready) q.push_back(model(op, a, b));
         end
      end
   endtask

   task automatic test_reset();
      bit acc, st;
      rst = 1; in_valid = 1; out_ready = 1; op = 3'd1; a = $urandom; b = $urandom;
      for (int i = 0; i < 2; i++) begin
         step(acc, st);
         total++;
         if (out_valid !== 1'b0 || result !== 32'd0) begin
            bad++;
            $display("FAIL reset_out: out_valid=%b result=%h, required 0 0", out_valid, result);
         end
      end
      rst = 0; in_valid = 0;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || zero !== 1'b0 || all_ones !== 1'b0 || illegal !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: in_ready=%b out_valid=%b z=%b ao=%b il=%b, required 1 0 0 0 0",
                  in_ready, out_valid, zero, all_ones, illegal);
      end
   endtask

   task automatic test_op_sweep();
      bit acc, st;
      logic [31:0] tbl [5];
      tbl[0] = 32'h00F0_1234; tbl[1] = 32'hFFF0_FFFF; tbl[2] = 32'hFF00_EDCB;
      tbl[3] = 32'h000F_0000; tbl[4] = 32'hF000_0000;
      out_ready = 1; a = 32'hF0F0_1234; b = 32'h0FF0_FFFF;
      for (int c = 0; c < 7; c++) begin
         in_valid = c < 5;
         op = 3'(c % 5);
         step(acc, st);
         total++;
         if (c < 5 && !acc) begin
            bad++;
            $display("FAIL sweep_accept: beat %0d not accepted, required accepted", c);
         end
         if (c == 0 || c == 6) begin
            if (out_valid !== 1'b0) begin
               bad++;
               $display("FAIL sweep_latency: cycle %0d out_valid=%b, required 0", c, out_valid);
            end
         end else if (out_valid !== 1'b1 || result !== tbl[c-1]) begin
            bad++;
            $display("FAIL sweep_op%0d: out_valid=%b result=%h, required 1 %h", c - 1, out_valid, result, tbl[c-1]);
         end
      end
   endtask

   task automatic test_flags();
      bit acc, st;
      out_ready = 1;
      in_valid = 1; op = 3'd2; a = 32'hDEAD_BEEF; b = 32'hDEAD_BEEF;
      step(acc, st);
      op = 3'd3; a = 32'd0; b = 32'd0;
      step(acc, st);
      in_valid = 0;
      total++;
      if (out_valid !== 1'b1 || zero !== 1'b1 || all_ones !== 1'b0 || result !== 32'd0) begin
         bad++;
         $display("FAIL flag_zero: v=%b z=%b ao=%b r=%h, required 1 1 0 00000000", out_valid, zero, all_ones, result);
      end
      step(acc, st);
      total++;
      if (out_valid !== 1'b1 || zero !== 1'b0 || all_ones !== 1'b1 || result !== 32'hFFFF_FFFF) begin
         bad++;
         $display("FAIL flag_ones: v=%b z=%b ao=%b r=%h, required 1 0 1 ffffffff", out_valid, zero, all_ones, result);
      end
      step(acc, st);
   endtask

   task automatic test_backpressure();
      bit acc, st, saw_stall;
      int sent, rx0, cyc;
      sent = 0; rx0 = rx_cnt; cyc = 0; saw_stall = 0;
      while ((sent < 6 || rx_cnt - rx0 < 6) && cyc < 100) begin
         out_ready = (cyc % 3 == 0);
         in_valid = sent < 6;
         if (acc || cyc == 0) begin
            op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
         end
         step(acc, st);
         if (acc) sent++;
         if (st) saw_stall = 1;
         cyc++;
      end
      in_valid = 0; out_ready = 1;
      total++;
      if (sent != 6 || rx_cnt - rx0 != 6 || q.size() != 0) begin
         bad++;
         $display("FAIL bp_count: sent=%0d received=%0d pending=%0d, required 6 6 0", sent, rx_cnt - rx0, q.size());
      end
      total++;
      if (!saw_stall) begin
         bad++;
         $display("FAIL bp_stall: in_ready never dropped, required a drop");
      end
   endtask

   task automatic test_flush();
      bit acc, st;
      exp_t e;
      int n;
      out_ready = 0; n = 0;
      for (int i = 0; i < 10 && n < 2; i++) begin
         in_valid = 1; op = 3'($urandom_range(0, 6)); a = $urandom; b = $urandom;
         step(acc, st);
         if (acc) n++;
      end
      op = 3'd1; a = $urandom; b = $urandom; flush = 1; in_valid = 1;
      step(acc, st);
      flush = 0; in_valid = 0;
      total++;
      if (n != 2 || out_valid !== 1'b0 || q.size() != 0) begin
         bad++;
         $display("FAIL flush_clear: loaded=%0d out_valid=%b pending=%0d, required 2 0 0", n, out_valid, q.size());
      end
      out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         step(acc, st);
         total++;
         if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_ghost: out_valid=%b, required 0", out_valid);
         end
      end
      in_valid = 1; op = 3'd4; a = $urandom; b = $urandom;
      e = model(op, a, b);
      step(acc, st);
      in_valid = 0;
      step(acc, st);
      total++;
      if (out_valid !== 1'b1 || result !== e.r) begin
         bad++;
         $display("FAIL flush_after: out_valid=%b result=%h, required 1 %h", out_valid, result, e.r);
      end
      step(acc, st);
   endtask

   task automatic test_random();
      bit acc, st;
      int k;
      for (int i = 0; i < 300; i++) begin
         out_ready = $urandom_range(0, 3) != 0;
         if (acc || !in_valid) begin
            in_valid = $urandom_range(0, 1);
            op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
         end
         step(acc, st);
      end
      in_valid = 0; out_ready = 1; k = 0;
      while (q.size() != 0 && k < 20) begin
         step(acc, st);
         k++;
      end
      total++;
      if (q.size() != 0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL random_drain: pending=%0d out_valid=%b, required 0 0", q.size(), out_valid);
      end
   endtask

   task automatic test_small();
      s_out_ready = 1;
      s_in_valid = 1; s_op = 3'd7; s_a = 8'hFF; s_b = 8'($urandom);
      @(posedge clk); #1;
      total++;
      if (s_out_valid !== 1'b1 || s_result !== 8'h00 || s_zero !== 1'b1 || s_all_ones !== 1'b0 || s_illegal !== 1'b1) begin
         bad++;
         $display("FAIL small_rsvd: v=%b r=%h z=%b ao=%b il=%b, required 1 00 1 0 1",
                  s_out_valid, s_result, s_zero, s_all_ones, s_illegal);
      end
      s_op = 3'd0; s_a = 8'hAA; s_b = 8'h0F;
      @(posedge clk); #1;
      s_in_valid = 0;
      total++;
      if (s_out_valid !== 1'b1 || s_result !== 8'h0A || s_zero !== 1'b0 || s_illegal !== 1'b0) begin
         bad++;
         $display("FAIL small_and: v=%b r=%h z=%b il=%b, required 1 0a 0 0", s_out_valid, s_result, s_zero, s_illegal);
      end
      @(posedge clk); #1;
      total++;
      if (s_out_valid !== 1'b0) begin
         bad++;
         $display("FAIL small_empty: out_valid=%b, required 0", s_out_valid);
      end
   endtask

   initial begin
      clk = 0; rst = 1; flush = 0; in_valid = 0; out_ready = 1; op = 0; a = 0; b = 0;
      s_in_valid = 0; s_out_ready = 1; s_op = 0; s_a = 0; s_b = 0;
      total = 0; bad = 0; rx_cnt = 0;
      fork
         monitor();
      join_none
      test_reset();
      test_op_sweep();
      test_flags();
      test_backpressure();
      test_flush();
      test_random();
      test_small();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
Parametrised, pipelined successor to the single-bit AND primitive. Performs a selectable bitwise operation on two WIDTH-bit operands, carries the result through STAGES elastic register slices with valid/ready handshaking, and produces zero and all-ones flags. Sits between operand fetch and writeback in the multi-cycle datapath and replaces the discrete gate instances there.

Parameters:
WIDTH, 32, operand and result width in bits (legal range 1..64)
STAGES, 2, number of pipeline register slices (legal range 1..4); sets latency in cycles

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand beat presented
in_ready  output  1  unit accepts the beat this cycle
op  input  3  operation select, sampled with the beat
a  input  WIDTH  operand A
b  input  WIDTH  operand B
flush  input  1  discard all in-flight beats
out_valid  output  1  result beat presented
out_ready  input  1  downstream accepts the result
result  output  WIDTH  operation result
zero  output  1  result is all zeros
all_ones  output  1  result is all ones
illegal  output  1  beat carried a reserved opcode

Behaviour:
- Single clock domain, clk; rst is synchronous and active-high.
- Opcodes: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 ANDN (a & ~b), 101 PASS_A, 110 PASS_B, 111 reserved.
- Reserved opcode: result = 0, zero = 1, all_ones = 0, illegal = 1. The beat still flows through and is not dropped.
- The operation, zero and all_ones are computed combinationally from the accepted inputs and captured in slice 0. Later slices only carry {result, zero, all_ones, illegal}.
- Each slice holds a valid bit and a data register.
  - Slice i advances when its downstream can take data, i.e. the next slice is empty or advancing. For the last slice, "downstream can take" means out_ready.
  - A slice loads when it is empty or advancing.
- in_ready = slice 0 empty or slice 0 advancing. This is combinational from out_ready through the slices; there is no skid buffer.
- Handshake: a beat transfers on the input when in_valid && in_ready, and on the output when out_valid && out_ready.
  - out_valid, result and the flags stay stable while out_valid && !out_ready.
  - in_valid may be held while in_ready is low.
- Latency: with out_ready held high, a beat accepted at edge N is presented (out_valid = 1) after edge N+STAGES-1. With STAGES = 1 it is presented in the cycle after acceptance. Sustained throughput is 1 beat per cycle.
- Full pipe with out_ready low: in_ready goes low and no beat is lost or duplicated.
- Bubbles: an empty slice collapses when the next input arrives, so a gap does not add latency to later beats.
- flush = 1 clears every valid bit at the next edge. A beat offered in the same cycle is dropped, and in_ready is still reported as computed. Data registers need not clear.
- flush and rst have equal effect on valid bits. rst also clears all data registers.
- Reset values: out_valid = 0, result = 0, zero = 0, all_ones = 0, illegal = 0, all slice valid bits = 0.
- Reset mid-operation discards all beats. in_ready = 1 in the first cycle after reset.
- WIDTH = 1 degenerates to a registered single-bit gate; zero = !result and all_ones = result.

Decomposition:
- Package logic_pkg:
  - op_t 3-bit enum (OP_AND, OP_OR, OP_XOR, OP_NOR, OP_ANDN, OP_PASS_A, OP_PASS_B, OP_RSVD)
  - localparam OP_W = 3
- Sub-module pipe_slice: one elastic register slice.
  - Parameter DW.
  - Ports clk, rst, flush, up_valid, up_ready, up_data, dn_valid, dn_ready, dn_data.
  - Instantiated STAGES times in a generate loop; the payload width is WIDTH+3.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid = 1 -> out_valid = 0, result = 0, in_ready = 1 in the cycle after rst falls.
- Op sweep, WIDTH = 32, STAGES = 2, out_ready = 1, a = 0xF0F0_1234, b = 0x0FF0_FFFF:
  - AND -> 0x00F0_1234
  - OR -> 0xFFF0_FFFF
  - XOR -> 0xFF00_EDCB
  - NOR -> 0x000F_0000
  - ANDN -> 0xF000_0000
  - Each result appears 2 cycles after acceptance, at one result per cycle.
- Flags: XOR with a = b = 0xDEAD_BEEF -> zero = 1. NOR with a = b = 0 -> all_ones = 1, result = 0xFFFF_FFFF.
- Backpressure: stream 6 beats while out_ready toggles 1,0,0,1,... -> in_ready drops once the pipe is full; outputs appear in order with no loss or duplicate; result stays stable while stalled.
- Flush: 2 beats in flight, pulse flush for 1 cycle while offering a third beat -> out_valid = 0 next cycle and none of the 3 beats ever appears; a beat sent afterwards emerges normally.
- Reserved op plus small config, WIDTH = 8, STAGES = 1: op = 111, a = 0xFF -> after 1 cycle result = 0x00, zero = 1, illegal = 1; next beat AND 0xAA & 0x0F -> result 0x0A, illegal = 0.
